// File: rtl/universal_shift_reg.sv
// ============================================================================
// Module   : universal_shift_reg
// Brief    : WIDTH-bit register with hold/load/shift/rotate modes and a
//            one-shot MSB-first serialiser with BUSY/DONE handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             REST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN_L,
    input  logic             SIN_R,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   c_last = CW'(WIDTH - 1);

    localparam logic [2:0] c_mode_hold = 3'b000;
    localparam logic [2:0] c_mode_load = 3'b001;
    localparam logic [2:0] c_mode_shl  = 3'b010;
    localparam logic [2:0] c_mode_shr  = 3'b011;
    localparam logic [2:0] c_mode_rol  = 3'b100;
    localparam logic [2:0] c_mode_ror  = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (REST) begin
            state_q <= S_IDLE;
            q_q     <= RESET_VAL;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // DONE defaults low so the pulse self-clears even while EN is low.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (EN) begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        q_d     = D;
                        busy_d  = 1'b1;
                        cnt_d   = c_last;
                        state_d = S_SHIFT;
                    end else begin
                        case (MODE)
                            c_mode_hold: q_d = q_q;
                            c_mode_load: q_d = D;
                            c_mode_shl:  q_d = {q_q[WIDTH-2:0], SIN_R};
                            c_mode_shr:  q_d = {SIN_L, q_q[WIDTH-1:1]};
                            c_mode_rol:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                            c_mode_ror:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                            default:     q_d = q_q;
                        endcase
                    end
                end
                S_SHIFT: begin
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign SOUT = q_q[WIDTH-1];
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

`default_nettype wire
